// File: rtl/wdist_pkg.sv
// Shared constants, state encoding and bank-select helper for the weight distributor.
// Optional checksum feature is controlled by WDIST_CHECKSUM_EN (see weight_distributor.sv).
package wdist_pkg;

    localparam int TM          = 8;
    localparam int TN          = 2;
    localparam int KERNEL_SIZE = 9;
    localparam int WPB         = KERNEL_SIZE * TN;
    localparam int DATA_W      = 16;
    localparam int BANK_ADR_W  = 5;
    localparam int BANK_SEL_W  = $clog2(TM);
    localparam int CSUM_W      = DATA_W + 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } wdist_state_t;

    // One-hot write enable for the selected output-map bank.
    function automatic logic [TM-1:0] bank_onehot(input logic [BANK_SEL_W-1:0] b);
        logic [TM-1:0] oh;
        oh    = '0;
        oh[b] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/weight_distributor_if.sv
// Read-data in / weight-bank write out bundle of the weight distributor.
// Checksum signals exist only when WDIST_CHECKSUM_EN is defined.
interface weight_distributor_if;
    import wdist_pkg::*;

    logic                  start;
    logic [DATA_W-1:0]     sdram_rdata;
    logic                  sdram_rdata_valid;
    logic [TM-1:0]         wbuf_we;
    logic [BANK_ADR_W-1:0] wbuf_addr;
    logic [DATA_W-1:0]     wbuf_wdata;
    logic                  busy;
    logic                  done;
    logic                  stray_beat;
`ifdef WDIST_CHECKSUM_EN
    logic [CSUM_W-1:0]     checksum;
    logic                  checksum_valid;
`endif

`ifdef WDIST_CHECKSUM_EN
    modport master (
        output start, sdram_rdata, sdram_rdata_valid,
        input  wbuf_we, wbuf_addr, wbuf_wdata,
        input  busy, done, stray_beat,
        input  checksum, checksum_valid
    );

    modport slave (
        input  start, sdram_rdata, sdram_rdata_valid,
        output wbuf_we, wbuf_addr, wbuf_wdata,
        output busy, done, stray_beat,
        output checksum, checksum_valid
    );
`else
    modport master (
        output start, sdram_rdata, sdram_rdata_valid,
        input  wbuf_we, wbuf_addr, wbuf_wdata,
        input  busy, done, stray_beat
    );

    modport slave (
        input  start, sdram_rdata, sdram_rdata_valid,
        output wbuf_we, wbuf_addr, wbuf_wdata,
        output busy, done, stray_beat
    );
`endif

endinterface

// File: rtl/wdist_beat_counter.sv
// Two-level beat counter: k walks the words of one bank, b walks the banks.
// last flags the final beat of the tile (b == TM-1, k == WPB-1).
module wdist_beat_counter
    import wdist_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [BANK_ADR_W-1:0] k,
    output logic [BANK_SEL_W-1:0] b,
    output logic                  last
);

    localparam logic [BANK_ADR_W-1:0] K_LAST = BANK_ADR_W'(WPB - 1);
    localparam logic [BANK_SEL_W-1:0] B_LAST = BANK_SEL_W'(TM - 1);

    // Word index wraps at the bank boundary and carries into the bank index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
            b <= '0;
        end else if (clr) begin
            k <= '0;
            b <= '0;
        end else if (inc) begin
            if (k == K_LAST) begin
                k <= '0;
                b <= b + 1'b1;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    assign last = (k == K_LAST) && (b == B_LAST);

endmodule

// File: rtl/weight_distributor.sv
// Routes SDRAM read beats into the TM per-output-map weight banks.
// Define WDIST_CHECKSUM_EN to add a per-tile sum of accepted beats.
module weight_distributor
    import wdist_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    weight_distributor_if.slave  bus
);

    wdist_state_t          state;
    logic [BANK_ADR_W-1:0] k;
    logic [BANK_SEL_W-1:0] b;
    logic                  last;
    logic                  cnt_clr;
    logic                  accept;

    assign cnt_clr = (state == IDLE) && bus.start;
    assign accept  = (state == FILL) && bus.sdram_rdata_valid;

    wdist_beat_counter u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (accept),
        .k    (k),
        .b    (b),
        .last (last)
    );

    // Control FSM with registered bank-write and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.wbuf_we    <= '0;
            bus.wbuf_addr  <= '0;
            bus.wbuf_wdata <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.stray_beat <= 1'b0;
        end else begin
            bus.wbuf_we <= '0;
            bus.done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.sdram_rdata_valid) begin
                        bus.stray_beat <= 1'b1;
                    end
                    if (bus.start) begin
                        state    <= FILL;
                        bus.busy <= 1'b1;
                    end
                end
                FILL: begin
                    if (bus.sdram_rdata_valid) begin
                        bus.wbuf_we    <= bank_onehot(b);
                        bus.wbuf_addr  <= k;
                        bus.wbuf_wdata <= bus.sdram_rdata;
                        if (last) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WDIST_CHECKSUM_EN
    // Running sum of accepted beats; cleared when a new tile starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.checksum       <= '0;
            bus.checksum_valid <= 1'b0;
        end else begin
            bus.checksum_valid <= accept && last;
            if (cnt_clr) begin
                bus.checksum <= '0;
            end else if (accept) begin
                bus.checksum <= bus.checksum + CSUM_W'(bus.sdram_rdata);
            end
        end
    end
`endif

endmodule

// File: tb/tb_weight_distributor.sv
// Directed + randomized bench for weight_distributor with a beat-count reference model.
// Checksum checks are active when WDIST_CHECKSUM_EN is defined.
module tb_weight_distributor;
    import wdist_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    weight_distributor_if bus ();

    weight_distributor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 filling, 2 done cycle; n beats taken.
    int                phase;
    int                n;
    logic              m_stray;
    logic [TM-1:0]     e_we;
    int                e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic              e_done;
    longint            m_sum;
    int                done_cnt;

    logic [DATA_W-1:0] emem [TM][WPB];
    logic [DATA_W-1:0] dmem [TM][WPB];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic s, input logic v,
                         input logic [DATA_W-1:0] d);
        e_we   = '0;
        e_done = 1'b0;
        case (phase)
            0: begin
                if (v) m_stray = 1'b1;
                if (s) begin
                    phase = 1;
                    n     = 0;
                    m_sum = 0;
                end
            end
            1: begin
                if (v) begin
                    e_we[n / WPB] = 1'b1;
                    e_addr  = n % WPB;
                    e_wdata = d;
                    emem[n / WPB][n % WPB] = d;
                    m_sum = (m_sum + longint'(d)) % (longint'(1) << CSUM_W);
                    n++;
                    if (n == TM * WPB) begin
                        phase  = 2;
                        e_done = 1'b1;
                    end
                end
            end
            default: phase = 0;
        endcase
    endtask

    task automatic compare();
        chk("we", 32'(bus.wbuf_we), 32'(e_we));
        chk("done", 32'(bus.done), 32'(e_done));
        chk("busy", 32'(bus.busy), 32'(phase == 1));
        chk("stray", 32'(bus.stray_beat), 32'(m_stray));
        if (e_we != '0) begin
            chk("addr", 32'(bus.wbuf_addr), 32'(e_addr));
            chk("wdata", 32'(bus.wbuf_wdata), 32'(e_wdata));
        end
`ifdef WDIST_CHECKSUM_EN
        chk("csum_valid", 32'(bus.checksum_valid), 32'(e_done));
        chk("csum", 32'(bus.checksum), 32'(m_sum));
`endif
    endtask

    task automatic capture();
        for (int i = 0; i < TM; i++) begin
            if (bus.wbuf_we[i]) dmem[i][bus.wbuf_addr] = bus.wbuf_wdata;
        end
        if (bus.done) done_cnt++;
    endtask

    task automatic step(input logic s, input logic v,
                        input logic [DATA_W-1:0] d);
        bus.start             = s;
        bus.sdram_rdata_valid = v;
        bus.sdram_rdata       = d;
        @(posedge clk);
        #1;
        model(s, v, d);
        compare();
        capture();
    endtask

    task automatic do_reset();
        bus.start             = 1'b0;
        bus.sdram_rdata_valid = 1'b0;
        bus.sdram_rdata       = '0;
        rst = 1'b1;
        #2;
        phase   = 0;
        n       = 0;
        m_stray = 1'b0;
        m_sum   = 0;
        chk("rst_we", 32'(bus.wbuf_we), 32'd0);
        chk("rst_addr", 32'(bus.wbuf_addr), 32'd0);
        chk("rst_wdata", 32'(bus.wbuf_wdata), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_stray", 32'(bus.stray_beat), 32'd0);
`ifdef WDIST_CHECKSUM_EN
        chk("rst_csum", 32'(bus.checksum), 32'd0);
        chk("rst_csum_valid", 32'(bus.checksum_valid), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic bank_check(input string tag);
        int errs;
        errs = 0;
        for (int bi = 0; bi < TM; bi++) begin
            for (int ki = 0; ki < WPB; ki++) begin
                if (dmem[bi][ki] !== emem[bi][ki]) errs++;
            end
        end
        chk(tag, 32'(errs), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int errs;

        rst                   = 1'b1;
        bus.start             = 1'b0;
        bus.sdram_rdata_valid = 1'b0;
        bus.sdram_rdata       = '0;
        phase   = 0;
        n       = 0;
        m_stray = 1'b0;
        m_sum   = 0;
        done_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Nominal fill, values 0..143 back to back
        done_cnt = 0;
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < TM * WPB; i++) begin
            step(1'b0, 1'b1, DATA_W'(i));
            if (i == 17) begin
                chk("bnd17_we", 32'(bus.wbuf_we), 32'h01);
                chk("bnd17_addr", 32'(bus.wbuf_addr), 32'd17);
            end
            if (i == 18) begin
                chk("bnd18_we", 32'(bus.wbuf_we), 32'h02);
                chk("bnd18_addr", 32'(bus.wbuf_addr), 32'd0);
            end
            if (i == TM * WPB - 1) begin
                chk("nom_done_last", 32'(bus.done), 32'd1);
`ifdef WDIST_CHECKSUM_EN
                chk("nom_csum", 32'(bus.checksum), 32'd10296);
`endif
            end
        end
        step(1'b0, 1'b0, '0);
        errs = 0;
        for (int bi = 0; bi < TM; bi++) begin
            for (int ki = 0; ki < WPB; ki++) begin
                if (dmem[bi][ki] !== DATA_W'(18 * bi + ki)) errs++;
            end
        end
        chk("nom_banks", 32'(errs), 32'd0);
        chk("nom_done_cnt", 32'(done_cnt), 32'd1);

        // Gapped valid, same contents
        for (int bi = 0; bi < TM; bi++)
            for (int ki = 0; ki < WPB; ki++) dmem[bi][ki] = '0;
        done_cnt = 0;
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < TM * WPB; i++) begin
            step(1'b0, 1'b1, DATA_W'(i));
            step(1'b0, 1'b0, DATA_W'($urandom));
        end
        step(1'b0, 1'b0, '0);
        bank_check("gap_banks");
        chk("gap_done_cnt", 32'(done_cnt), 32'd1);

        // Stray beats in idle, then start ignored mid-fill
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DATA_W'($urandom));
        chk("stray_set", 32'(bus.stray_beat), 32'd1);
        done_cnt = 0;
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < TM * WPB; i++) begin
            step(i == 60 || i == 61, 1'b1, DATA_W'($urandom));
        end
        step(1'b1, 1'b1, DATA_W'($urandom));
        chk("midstart_done_cnt", 32'(done_cnt), 32'd1);
        bank_check("midstart_banks");

        // Start coincident with valid in idle: beat dropped, fill follows
        done_cnt = 0;
        step(1'b1, 1'b1, DATA_W'($urandom));
        for (int i = 0; i < TM * WPB; i++) begin
            while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, DATA_W'($urandom));
            step(1'b0, 1'b1, DATA_W'($urandom));
        end
        step(1'b0, 1'b0, '0);
        chk("sv_done_cnt", 32'(done_cnt), 32'd1);
        bank_check("sv_banks");

        // Reset mid-fill, then a clean fill
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, DATA_W'($urandom));
        do_reset();
        done_cnt = 0;
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < TM * WPB; i++) step(1'b0, 1'b1, DATA_W'($urandom));
        step(1'b0, 1'b0, '0);
        chk("rstfill_done_cnt", 32'(done_cnt), 32'd1);
        chk("rstfill_stray", 32'(bus.stray_beat), 32'd0);
        bank_check("rstfill_banks");

        // All-ones tile
        done_cnt = 0;
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < TM * WPB; i++) step(1'b0, 1'b1, 16'hFFFF);
`ifdef WDIST_CHECKSUM_EN
        chk("ones_csum", 32'(bus.checksum), 32'd9437040);
        chk("ones_csum_valid", 32'(bus.checksum_valid), 32'd1);
`endif
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
`ifdef WDIST_CHECKSUM_EN
        chk("ones_csum_hold", 32'(bus.checksum), 32'd9437040);
`endif
        chk("ones_done_cnt", 32'(done_cnt), 32'd1);

        // Random traffic with random starts
        for (int i = 0; i < 1500; i++) begin
            d = DATA_W'($urandom);
            step($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
